alu_seq: RTL and testbench

//  Parametrised next-generation MIPS ALU: registered single-cycle logic/arith ops plus an

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_seq_muldiv_iter.sv | 132 +++++++++++++
 rtl/alu_seq.sv | 113 +++++++++++
 tb/tb_alu_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential MIPS ALU: opcode encoding and mul/div sequencer states.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND   = 4'h0,
      OP_OR    = 4'h1,
      OP_ADD   = 4'h2,
      OP_SLTU  = 4'h3,
      OP_ANDN  = 4'h4,
      OP_ORN   = 4'h5,
      OP_SUB   = 4'h6,
      OP_SLT   = 4'h7,
      OP_MULT  = 4'h8,
      OP_MULTU = 4'h9,
      OP_DIV   = 4'hA,
      OP_DIVU  = 4'hB,
      OP_MFHI  = 4'hC,
      OP_MFLO  = 4'hD,
      OP_RSV_E = 4'hE,
      OP_RSV_F = 4'hF
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } muldiv_state_e;

   function automatic logic is_muldiv(input alu_op_e op);
      return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
   endfunction

   function automatic logic is_mul(input alu_op_e op);
      return op inside {OP_MULT, OP_MULTU};
   endfunction

endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// Iterative multiply/divide core: WIDTH-cycle shift-add multiply and restoring divide on
// operand magnitudes, with sign correction and the divide special cases applied on the last step.
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  alu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_res,
   output logic [WIDTH-1:0] lo_res,
   output logic             ovf_res
);

   localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

   muldiv_state_e      state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   m;
   logic [2*WIDTH-1:0] acc;
   logic               neg;
   logic               rneg;
   logic               dz;
   logic               dovf;
   logic [WIDTH-1:0]   a_save;

   logic               sgn;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     r_sh;
   logic               ge;
   logic [WIDTH-1:0]   diff;
   logic [2*WIDTH-1:0] acc_n;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   always_comb begin
      sgn   = (op == OP_MULT) || (op == OP_DIV);
      a_neg = sgn & a[WIDTH-1];
      b_neg = sgn & b[WIDTH-1];
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;
   end

   // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
   // The remainder never exceeds WIDTH bits, so only the compare needs the extra shifted-out bit.
   always_comb begin
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
      r_sh    = acc[2*WIDTH-1:WIDTH-1];
      ge      = r_sh >= {1'b0, m};
      diff    = r_sh[WIDTH-1:0] - m;
      if (state == MUL)
         acc_n = {mul_sum, acc[WIDTH-1:1]};
      else if (ge)
         acc_n = {diff, acc[WIDTH-2:0], 1'b1};
      else
         acc_n = {r_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
   end

   always_comb begin
      prod = neg ? -acc_n : acc_n;
      quo  = neg ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
      rem  = rneg ? -acc_n[2*WIDTH-1:WIDTH] : acc_n[2*WIDTH-1:WIDTH];
      busy = (state != IDLE);
      done = busy && (cnt == '0);
      if (state == MUL) begin
         hi_res  = prod[2*WIDTH-1:WIDTH];
         lo_res  = prod[WIDTH-1:0];
         ovf_res = 1'b0;
      end else if (dz) begin
         hi_res  = a_save;
         lo_res  = '1;
         ovf_res = 1'b0;
      end else begin
         hi_res  = rem;
         lo_res  = quo;
         ovf_res = dovf;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         m      <= '0;
         acc    <= '0;
         neg    <= 1'b0;
         rneg   <= 1'b0;
         dz     <= 1'b0;
         dovf   <= 1'b0;
         a_save <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= is_mul(op) ? MUL : DIV;
                  cnt    <= CNT_W'(WIDTH - 1);
                  m      <= is_mul(op) ? a_mag : b_mag;
                  acc    <= {{WIDTH{1'b0}}, (is_mul(op) ? b_mag : a_mag)};
                  neg    <= a_neg ^ b_neg;
                  rneg   <= a_neg;
                  dz     <= !is_mul(op) && (b == '0);
                  dovf   <= (op == OP_DIV) && (a == MIN_V) && (b == '1);
                  a_save <= a;
               end
            end
            MUL, DIV: begin
               acc <= acc_n;
               if (cnt == '0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/alu_seq.sv
// EX-stage ALU: registered single-cycle ops, HI/LO architectural registers, and a
// valid/ready handshake that stalls issue while the iterative mul/div core is busy.
module alu_seq
   import alu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             ovf,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   alu_op_e          opc;
   logic             accept;
   logic             md_op;
   logic             md_busy;
   logic             md_done;
   logic [WIDTH-1:0] md_hi;
   logic [WIDTH-1:0] md_lo;
   logic             md_ovf;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] dif;
   logic [WIDTH-1:0] r;
   logic             r_ovf;

   assign opc      = alu_op_e'(op);
   assign in_ready = !md_busy;
   assign accept   = in_valid && in_ready;
   assign md_op    = is_muldiv(opc);

   muldiv_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_muldiv (
      .clk     (clk),
      .reset   (reset),
      .start   (accept && md_op),
      .op      (opc),
      .a       (a),
      .b       (b),
      .busy    (md_busy),
      .done    (md_done),
      .hi_res  (md_hi),
      .lo_res  (md_lo),
      .ovf_res (md_ovf)
   );

   always_comb begin
      sum   = a + b;
      dif   = a - b;
      r     = '0;
      r_ovf = 1'b0;
      case (opc)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_ADD: begin
            r     = sum;
            r_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLTU: r = WIDTH'(a < b);
         OP_ANDN: r = a & ~b;
         OP_ORN:  r = a | ~b;
         OP_SUB: begin
            r     = dif;
            r_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT:  r = WIDTH'($signed(a) < $signed(b));
         OP_MFHI: r = hi;
         OP_MFLO: r = lo;
         default: r = '0;
      endcase
   end

   // A mul/div completion and a new accept cannot coincide: in_ready is low until done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         y         <= '0;
         zero      <= 1'b1;
         ovf       <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         out_valid <= 1'b0;
         if (md_done) begin
            out_valid <= 1'b1;
            y         <= md_lo;
            zero      <= (md_lo == '0);
            ovf       <= md_ovf;
            hi        <= md_hi;
            lo        <= md_lo;
         end else if (accept && !md_op) begin
            out_valid <= 1'b1;
            y         <= r;
            zero      <= (r == '0);
            ovf       <= r_ovf;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized ops against a
// plain-arithmetic reference model of the ALU and its HI/LO registers.
module tb_alu_seq;

   localparam int W = 32;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;
   localparam logic [W-1:0] MINV = 32'h8000_0000;
   localparam logic [W-1:0] MAXV = 32'h7FFF_FFFF;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic [W-1:0] y;
   logic         zero;
   logic         ovf;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   logic [W-1:0] e_y  = '0;
   logic         e_ovf = 1'b0;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .y         (y),
      .zero      (zero),
      .ovf       (ovf),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Architectural behaviour from the instruction definitions, using 64-bit arithmetic.
   task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z,
                        inout logic [W-1:0] h, inout logic [W-1:0] l,
                        output logic [W-1:0] r, output logic v);
      longint sx, sz, s;
      logic [63:0] p;
      sx = $signed(x);
      sz = $signed(z);
      r = '0;
      v = 1'b0;
      case (o)
         4'h0: r = x & z;
         4'h1: r = x | z;
         4'h2: begin s = sx + sz; r = s[31:0]; v = (s > SMAX) || (s < SMIN); end
         4'h3: r = {31'b0, x < z};
         4'h4: r = x & ~z;
         4'h5: r = x | ~z;
         4'h6: begin s = sx - sz; r = s[31:0]; v = (s > SMAX) || (s < SMIN); end
         4'h7: r = {31'b0, sx < sz};
         4'h8: begin s = sx * sz; h = s[63:32]; l = s[31:0]; r = l; end
         4'h9: begin p = 64'(x) * 64'(z); h = p[63:32]; l = p[31:0]; r = l; end
         4'hA: begin
            if (z == '0) begin l = '1; h = x; end
            else begin
               s = sx / sz; l = s[31:0]; v = (s > SMAX);
               s = sx % sz; h = s[31:0];
            end
            r = l;
         end
         4'hB: begin
            if (z == '0) begin l = '1; h = x; end
            else begin l = x / z; h = x % z; end
            r = l;
         end
         4'hC: r = h;
         4'hD: r = l;
         default: r = '0;
      endcase
   endtask

   task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z,
                         input bit keep_valid, input string tag);
      int n;
      model(o, x, z, m_hi, m_lo, e_y, e_ovf);
      @(negedge clk);
      in_valid = 1'b1; op = o; a = x; b = z;
      @(posedge clk); #1;
      if (o inside {4'h8, 4'h9, 4'hA, 4'hB}) begin
         n = 0;
         while (!out_valid && n < 100) begin
            check({tag, " busy"}, in_ready, 0);
            // Requests while busy must be ignored.
            in_valid = 1'($urandom_range(1));
            op = 4'($urandom_range(7));
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            n++;
         end
         in_valid = 1'b0;
         check({tag, " latency"}, n, W);
      end else if (!keep_valid) begin
         in_valid = 1'b0;
      end
      check({tag, " out_valid"}, out_valid, 1);
      check({tag, " y"}, y, e_y);
      check({tag, " zero"}, zero, e_y == '0);
      check({tag, " ovf"}, ovf, e_ovf);
      check({tag, " hi"}, hi, m_hi);
      check({tag, " lo"}, lo, m_lo);
      check({tag, " in_ready"}, in_ready, 1);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(5))
         0: return '0;
         1: return 32'd1;
         2: return '1;
         3: return MINV;
         4: return MAXV;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;
      reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
      #1;
      check("rst in_ready", in_ready, 1);
      check("rst out_valid", out_valid, 0);
      check("rst y", y, 0);
      check("rst zero", zero, 1);
      check("rst ovf", ovf, 0);
      check("rst hi", hi, 0);
      check("rst lo", lo, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;

      run_op(4'h2, 32'd7, -32'sd3, 0, "add 7,-3");
      @(posedge clk); #1;
      check("hold out_valid", out_valid, 0);
      check("hold y", y, e_y);
      run_op(4'h2, MAXV, 32'd1, 0, "add ovf");

      run_op(4'h6, 32'd5, 32'd5, 1, "sub 5,5");
      run_op(4'h7, '1, 32'd1, 1, "slt");
      run_op(4'h3, '1, 32'd1, 1, "sltu");
      run_op(4'h6, MINV, 32'd1, 1, "sub ovf");
      run_op(4'h4, 32'hF0F0_FFFF, 32'h0FF0_00FF, 1, "andn");
      run_op(4'h5, 32'h0, 32'hFFFF_0000, 0, "orn");

      run_op(4'h8, -32'sd2, 32'd3, 0, "mult -2,3");
      run_op(4'h9, '1, 32'd2, 0, "multu");
      run_op(4'hC, 32'd0, 32'd0, 1, "mfhi");
      run_op(4'hD, 32'd0, 32'd0, 0, "mflo");
      run_op(4'hA, -32'sd7, 32'd2, 0, "div -7,2");
      run_op(4'hB, 32'd7, 32'd0, 0, "divu by 0");
      run_op(4'hA, -32'sd9, 32'd0, 0, "div by 0");
      run_op(4'hA, MINV, '1, 0, "div min/-1");
      run_op(4'hE, 32'd3, 32'd4, 0, "reserved");

      // Reset partway through a multiply must abort it without a response.
      @(negedge clk);
      in_valid = 1'b1; op = 4'h8; a = -32'sd2; b = 32'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort in_ready", in_ready, 1);
      check("abort out_valid", out_valid, 0);
      check("abort hi", hi, 0);
      check("abort lo", lo, 0);
      check("abort y", y, 0);
      check("abort zero", zero, 1);
      @(negedge clk); reset = 1'b0;
      m_hi = '0; m_lo = '0;
      n = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) n++;
      end
      check("abort no response", n, 0);

      for (int i = 0; i < 80; i++) begin
         run_op(4'($urandom_range(15)), pick(), pick(), bit'($urandom_range(1)), "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
